// File: rtl/seq_datapath.sv
// Bus-based Mini SRC datapath with a built-in control-step sequencer.
// Every operand moves over one shared bus; multiply is single-cycle, divide is a restoring iteration.
module seq_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int RW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [RW-1:0]    ra,
    input  logic [RW-1:0]    rb,
    input  logic [RW-1:0]    rc,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] bus_out
);
    localparam int RW_S = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHRA = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_ROR  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_NEG  = 4'd11;
    localparam logic [3:0] OP_NOT  = 4'd12;
    localparam logic [3:0] OP_MFHI = 4'd13;
    localparam logic [3:0] OP_MFLO = 4'd14;
    localparam logic [3:0] OP_LDI  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T3,
        S_T4,
        S_DIVW,
        S_T5,
        S_T6
    } state_t;

    state_t             state_reg;
    logic [3:0]         op_reg;
    logic [RW-1:0]      ra_reg;
    logic [RW-1:0]      rb_reg;
    logic [RW-1:0]      rc_reg;
    logic [WIDTH-1:0]   imm_reg;
    logic [WIDTH-1:0]   y_reg;
    logic [2*WIDTH-1:0] z_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic [RW_S-1:0]    cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   rf_reg [NREGS];

    logic [WIDTH-1:0]   bus;
    logic               is_muldiv;
    logic [RW_S-1:0]    sh_amt;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
    logic [WIDTH-1:0]   sra_val;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic               rf_write;
    logic [NREGS-1:0]   rf_we;

    assign is_muldiv = (op_reg == OP_MUL) || (op_reg == OP_DIV);

    // Single shared bus: exactly one source per control step, zero when nothing drives it.
    always_comb begin
        bus = '0;
        case (state_reg)
            S_T3: begin
                case (op_reg)
                    OP_MFHI: bus = hi_reg;
                    OP_MFLO: bus = lo_reg;
                    OP_LDI:  bus = imm_reg;
                    default: bus = rf_reg[rb_reg];
                endcase
            end
            S_T4:    bus = rf_reg[rc_reg];
            S_T5:    bus = z_reg[WIDTH-1:0];
            S_T6:    bus = z_reg[2*WIDTH-1:WIDTH];
            default: bus = '0;
        endcase
    end

    assign sh_amt  = bus[RW_S-1:0];
    assign rot_r   = {y_reg, y_reg} >> sh_amt;
    assign rot_l   = {y_reg, y_reg} << sh_amt;
    assign sra_val = $signed(y_reg) >>> sh_amt;
    // Sign-extended operands make the low 2*WIDTH bits of the product the signed result.
    assign prod    = {{WIDTH{y_reg[WIDTH-1]}}, y_reg} * {{WIDTH{bus[WIDTH-1]}}, bus};

    always_comb begin
        alu_lo = y_reg;
        alu_hi = '0;
        case (op_reg)
            OP_ADD:  alu_lo = y_reg + bus;
            OP_SUB:  alu_lo = y_reg - bus;
            OP_AND:  alu_lo = y_reg & bus;
            OP_OR:   alu_lo = y_reg | bus;
            OP_SHR:  alu_lo = y_reg >> sh_amt;
            OP_SHRA: alu_lo = sra_val;
            OP_SHL:  alu_lo = y_reg << sh_amt;
            OP_ROR:  alu_lo = rot_r[WIDTH-1:0];
            OP_ROL:  alu_lo = rot_l[2*WIDTH-1:WIDTH];
            OP_MUL:  {alu_hi, alu_lo} = prod;
            OP_NEG:  alu_lo = '0 - y_reg;
            OP_NOT:  alu_lo = ~y_reg;
            default: alu_lo = y_reg;
        endcase
    end

    // Restoring step: the partial remainder stays below the divisor, so the borrow bit decides.
    assign div_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, dvs_reg};
    assign div_ge    = ~div_diff[WIDTH];
    assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quo_next  = {quo_reg[WIDTH-2:0], div_ge};

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            ra_reg    <= '0;
            rb_reg    <= '0;
            rc_reg    <= '0;
            imm_reg   <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        ra_reg    <= ra;
                        rb_reg    <= rb;
                        rc_reg    <= rc;
                        imm_reg   <= imm;
                        state_reg <= S_T3;
                        busy_reg  <= 1'b1;
                    end
                end
                S_T3: begin
                    y_reg     <= bus;
                    state_reg <= S_T4;
                end
                S_T4: begin
                    if (op_reg == OP_DIV) begin
                        if (bus == '0) begin
                            z_reg     <= {y_reg, {WIDTH{1'b1}}};
                            state_reg <= S_T5;
                        end else begin
                            rem_reg   <= '0;
                            quo_reg   <= y_reg;
                            dvs_reg   <= bus;
                            cnt_reg   <= '0;
                            state_reg <= S_DIVW;
                        end
                    end else begin
                        z_reg     <= {alu_hi, alu_lo};
                        state_reg <= S_T5;
                        done_reg  <= (op_reg != OP_MUL);
                    end
                end
                S_DIVW: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == RW_S'(WIDTH - 1)) begin
                        z_reg     <= {rem_next, quo_next};
                        state_reg <= S_T5;
                    end
                end
                S_T5: begin
                    if (is_muldiv) begin
                        lo_reg    <= bus;
                        state_reg <= S_T6;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                S_T6: begin
                    hi_reg    <= bus;
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rf_write = (state_reg == S_T5) && !is_muldiv;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf_we
            assign rf_we[gi] = rf_write && (ra_reg == RW'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (rf_we[i]) begin
                    rf_reg[i] <= bus;
                end
            end
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign hi_out   = hi_reg;
    assign lo_out   = lo_reg;
    assign bus_out  = bus;
    assign dbg_data = rf_reg[dbg_sel];

endmodule

// File: tb/tb_seq_datapath.sv
// Directed and randomized bench for seq_datapath at 32x16 and 8x4, checked against an arithmetic model.
module tb_seq_datapath;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, start, use8;
    logic [3:0]  op, ra, rb, rc, dbg_sel;
    logic [31:0] imm;

    logic        busy32, done32, busy8, done8;
    logic [31:0] dbg32, hi32, lo32, bus32;
    logic [7:0]  dbg8, hi8, lo8, bus8;

    logic        busy_m, done_m;
    logic [31:0] dbg_m, hi_m, lo_m, bus_m;
    assign busy_m = use8 ? busy8 : busy32;
    assign done_m = use8 ? done8 : done32;
    assign dbg_m  = use8 ? {24'd0, dbg8} : dbg32;
    assign hi_m   = use8 ? {24'd0, hi8}  : hi32;
    assign lo_m   = use8 ? {24'd0, lo8}  : lo32;
    assign bus_m  = use8 ? {24'd0, bus8} : bus32;

    seq_datapath dut32 (
        .clock(clock), .clear(clear), .start(start & ~use8), .op(op),
        .ra(ra), .rb(rb), .rc(rc), .imm(imm), .busy(busy32), .done(done32),
        .dbg_sel(dbg_sel), .dbg_data(dbg32), .hi_out(hi32), .lo_out(lo32), .bus_out(bus32)
    );

    seq_datapath #(.WIDTH(8), .NREGS(4)) dut8 (
        .clock(clock), .clear(clear), .start(start & use8), .op(op),
        .ra(ra[1:0]), .rb(rb[1:0]), .rc(rc[1:0]), .imm(imm[7:0]), .busy(busy8), .done(done8),
        .dbg_sel(dbg_sel[1:0]), .dbg_data(dbg8), .hi_out(hi8), .lo_out(lo8), .bus_out(bus8)
    );

    int total = 0;
    int bad   = 0;
    int w, nregs;
    logic [63:0] m_r [16];
    logic [63:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic longint sext(input logic [63:0] v);
        logic [63:0] top;
        top = 64'd1 << (w - 1);
        return longint'((v ^ top) - top);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic check_reg(input string tag, input int idx, input logic [63:0] exp);
        dbg_sel = 4'(idx);
        #1;
        check(tag, dbg_m, exp);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < nregs; i++) begin
            dbg_sel = 4'(i);
            #1;
            check(tag, dbg_m, m_r[i]);
        end
        @(negedge clock);
    endtask

    // Issues one instruction from a negedge; returns at negedge+1 of the cycle after done.
    task automatic issue(input int opc, input int a_d, input int b_s, input int c_s,
                         input logic [63:0] immv, input int pulse_at, input int abort_at);
        logic [63:0] mask, a, b, res_lo, res_hi, pu;
        longint p;
        int s, exp_lat, lat;
        mask = (64'd1 << w) - 1;
        case (opc)
            13:      a = m_hi;
            14:      a = m_lo;
            15:      a = immv & mask;
            default: a = m_r[b_s];
        endcase
        b = m_r[c_s];
        s = int'(b % 64'(w));
        res_hi = '0;
        case (opc)
            0:  res_lo = a + b;
            1:  res_lo = a - b;
            2:  res_lo = a & b;
            3:  res_lo = a | b;
            4:  res_lo = a >> s;
            5:  res_lo = 64'(sext(a) >>> s);
            6:  res_lo = a << s;
            7:  res_lo = (a >> s) | (a << (w - s));
            8:  res_lo = (a << s) | (a >> (w - s));
            9: begin
                p = sext(a) * sext(b);
                pu = 64'(p);
                res_lo = pu;
                res_hi = pu >> w;
            end
            10: begin
                if (b == 0) begin
                    res_lo = mask;
                    res_hi = a;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            11: res_lo = -a;
            12: res_lo = ~a;
            default: res_lo = a;
        endcase
        res_lo &= mask;
        res_hi &= mask;
        exp_lat = (opc == 9) ? 4 : (opc == 10) ? ((b == 0) ? 4 : w + 4) : 3;

        op = 4'(opc); ra = 4'(a_d); rb = 4'(b_s); rc = 4'(c_s); imm = 32'(immv);
        start = 1'b1;
        @(posedge clock);
        lat = 0;
        for (int k = 1; k <= exp_lat + 2 && lat == 0; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (k == pulse_at) begin
                start = 1'b1;
                op = 4'd15;
                ra = 4'(a_d ^ 1);
                imm = $urandom;
            end
            if (k == abort_at) begin
                clear = 1'b0;
                #1;
                check("abort_busy", busy_m, 0);
                check("abort_done", done_m, 0);
                check("abort_bus", bus_m, 0);
                model_reset();
                return;
            end
            check("busy_during", busy_m, 1);
            if (done_m) lat = k;
        end
        check("latency", lat, exp_lat);
        @(negedge clock);
        check("busy_after", busy_m, 0);
        check("done_after", done_m, 0);
        check("bus_idle", bus_m, 0);
        if (opc == 9 || opc == 10) begin
            m_lo = res_lo;
            m_hi = res_hi;
        end else begin
            m_r[a_d] = res_lo;
        end
        check("hi", hi_m, m_hi);
        check("lo", lo_m, m_lo);
        if (opc != 9 && opc != 10) begin
            dbg_sel = 4'(a_d);
            #1;
            check("rdest", dbg_m, m_r[a_d]);
        end
        $display("op=%0d ra=%0d rb=%0d rc=%0d lat=%0d lo=%0h hi=%0h", opc, a_d, b_s, c_s, lat, lo_m, hi_m);
    endtask

    task automatic random_ops(input int n);
        logic [63:0] mask;
        mask = (64'd1 << w) - 1;
        for (int i = 0; i < nregs; i++) issue(15, i, 0, 0, {$urandom, $urandom} & mask, 0, 0);
        for (int i = 0; i < n; i++) begin
            issue($urandom_range(0, 15), $urandom_range(0, nregs - 1), $urandom_range(0, nregs - 1),
                  $urandom_range(0, nregs - 1), {$urandom, $urandom} & mask, 0, 0);
        end
        sweep("rand_regs");
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; use8 = 1'b0;
        op = '0; ra = '0; rb = '0; rc = '0; imm = '0; dbg_sel = '0;
        w = 32; nregs = 16;
        model_reset();
        repeat (2) @(negedge clock);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_bus", bus_m, 0);
        check("rst_hi", hi_m, 0);
        check("rst_lo", lo_m, 0);
        sweep("rst_reg");
        clear = 1'b1;
        @(negedge clock);

        issue(15, 1, 0, 0, 7, 0, 0);
        issue(15, 2, 0, 0, 5, 0, 0);
        issue(0, 3, 1, 2, 0, 0, 0);
        check_reg("add_r3", 3, 12);
        issue(1, 4, 2, 1, 0, 0, 0);
        check_reg("sub_r4", 4, 64'hFFFF_FFFE);
        issue(15, 5, 0, 0, 64'h8000_0001, 0, 0);
        issue(15, 6, 0, 0, 1, 0, 0);
        issue(7, 7, 5, 6, 0, 0, 0);
        check_reg("ror_r7", 7, 64'hC000_0000);
        issue(15, 8, 0, 0, 64'h8000_0000, 0, 0);
        issue(15, 9, 0, 0, 4, 0, 0);
        issue(5, 10, 8, 9, 0, 0, 0);
        check_reg("shra_r10", 10, 64'hF800_0000);

        issue(15, 1, 0, 0, 64'hFFFF_FFFD, 0, 0);
        issue(15, 2, 0, 0, 4, 0, 0);
        issue(9, 0, 1, 2, 0, 0, 0);
        check("mul_lo", lo_m, 64'hFFFF_FFF4);
        check("mul_hi", hi_m, 64'hFFFF_FFFF);
        sweep("mul_regs");

        issue(15, 1, 0, 0, 100, 0, 0);
        issue(15, 2, 0, 0, 7, 0, 0);
        issue(10, 0, 1, 2, 0, 0, 0);
        check("div_lo", lo_m, 14);
        check("div_hi", hi_m, 2);
        issue(15, 2, 0, 0, 0, 0, 0);
        issue(10, 0, 1, 2, 0, 0, 0);
        check("div0_lo", lo_m, 64'hFFFF_FFFF);
        check("div0_hi", hi_m, 100);

        issue(15, 2, 0, 0, 7, 0, 0);
        issue(15, 3, 0, 0, 12, 0, 0);
        issue(10, 0, 1, 2, 0, 13, 0);
        check("pulse_lo", lo_m, 14);
        check("pulse_hi", hi_m, 2);
        sweep("pulse_regs");

        issue(10, 0, 1, 2, 0, 0, 8);
        check("abort_hi", hi_m, 0);
        check("abort_lo", lo_m, 0);
        sweep("abort_regs");
        clear = 1'b1;
        @(negedge clock);
        issue(15, 1, 0, 0, 9, 0, 0);
        issue(15, 2, 0, 0, 6, 0, 0);
        issue(0, 3, 1, 2, 0, 0, 0);
        check_reg("post_abort_add", 3, 15);

        random_ops(30);

        use8 = 1'b1;
        w = 8; nregs = 4;
        model_reset();
        @(negedge clock);
        issue(15, 0, 0, 0, 200, 0, 0);
        issue(15, 1, 0, 0, 3, 0, 0);
        issue(9, 0, 0, 1, 0, 0, 0);
        check("mul8_hi", hi_m, 64'hFF);
        check("mul8_lo", lo_m, 64'h58);
        random_ops(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised bus-based Mini SRC datapath with its own control-step sequencer. It holds a register file, the Y, Z, HI and LO registers, and a shift-capable ALU. It executes one R-type, immediate or HI/LO instruction per start/done handshake, moving every operand over a single shared bus. Multiply is single-cycle; divide is iterative. A debug port reads the register file.

## Interface
Parameters:
- WIDTH, 32: data width of bus, registers and ALU.
- NREGS, 16: number of general-purpose registers. Must be a power of two, at least 2.
- RW, $clog2(NREGS): register-select width (derived; not overridden).

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  instruction request; sampled only in IDLE.
- op  in  4  opcode (encoding below).
- ra, rb, rc  in  RW each  destination, source A, source B.
- imm  in  WIDTH  immediate value for LDI.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse in the final control step.
- dbg_sel  in  RW  debug register select.
- dbg_data  out  WIDTH  combinational R[dbg_sel].
- hi_out, lo_out  out  WIDTH  current HI and LO.
- bus_out  out  WIDTH  current bus value; 0 when no source drives the bus.

## Operation
- Opcode encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV, 11 NEG, 12 NOT, 13 MFHI, 14 MFLO, 15 LDI.
- Accept: when start=1 in IDLE, latch op, ra, rb, rc and imm into the instruction latch and go to T3. start in any other state is ignored; the latch is unchanged.
- T3: bus source is R[rb] (or HI for MFHI, LO for MFLO, imm for LDI). Y <= bus.
- T4, non-DIV ops:
  - Bus source is R[rc].
  - Z <= {hi, lo} of ALU(Y, bus).
  - For everything except MUL, Zhi = 0.
- T4, DIV: load the divider (dividend Y, divisor bus) and go to DIVW.
- ALU rules:
  - ADD and SUB wrap modulo 2^WIDTH; no flags.
  - Shift and rotate amount is bus[RW_S-1:0], where RW_S = $clog2(WIDTH).
  - SHRA is arithmetic. NEG = -Y. NOT = ~Y. MFHI, MFLO and LDI pass Y.
  - MUL is a signed WIDTH x WIDTH product giving a full 2*WIDTH result.
- DIVW: unsigned restoring division, one quotient bit per cycle, for exactly WIDTH cycles. It then sets Zlo = quotient, Zhi = remainder and goes to T5.
- Divide by zero: skip DIVW. Z <= {dividend, all-ones} in T4, then go to T5.
- T5, non-MUL/DIV ops: bus = Zlo; R[ra] <= bus; done=1; next state IDLE.
- T5, MUL/DIV: bus = Zlo; LO <= bus; next state T6.
- T6: bus = Zhi; HI <= bus; done=1; next state IDLE.
- ra == rb == rc is legal. Sources are captured in Y and Z before the write, so there is no hazard.

## Timing
- Reset values (clear=0, any time, asynchronous):
  - state IDLE.
  - All R[i], Y, Z, HI, LO and the instruction latch are 0.
  - busy=0, done=0, bus_out=0.
- Reset mid-operation aborts the instruction with no partial write.
- Latency, with the accept edge at cycle 0:
  - ALU ops and LDI/MF*: T3 at cycle 1, T4 at 2, T5 at 3 (done=1). The result is visible on dbg_data from cycle 4.
  - MUL: T5 at 3, T6 at 4 (done=1).
  - DIV: DIVW in cycles 3 to WIDTH+2, T5 at WIDTH+3, T6 at WIDTH+4 (done=1).
  - DIV by zero: done at cycle 4.
- busy is high from cycle 1 through the done cycle inclusive, and low in the cycle after done. A start in that cycle is accepted, so back-to-back issue is possible.
- done never asserts in IDLE and is never high for two consecutive cycles.

## Test plan
- LDI R1=7, then LDI R2=5, then ADD R3,R1,R2. Required: R3=12; done exactly 3 cycles after each accept; busy high for cycles 1-3.
- SUB R4,R2,R1 → R4=0xFFFFFFFE. ROR by 1 of R5=0x80000001 → 0xC0000000. SHRA by 4 of 0x80000000 → 0xF8000000.
- MUL with R1=-3 (0xFFFFFFFD) and R2=4. Required: LO=0xFFFFFFF4, HI=0xFFFFFFFF, done at cycle 4, no general register modified.
- DIV 100/7. Required: LO=14, HI=2, done at cycle 36. DIV 100/0: LO=0xFFFFFFFF, HI=100, done at cycle 4.
- Pulse start during DIVW cycle 10. Required: ignored, and the original result is intact. Then drive clear=0 during a second DIV's DIVW. Required: busy=0 immediately, HI=LO=0, all registers 0, and the next instruction runs normally.
- Instantiate with WIDTH=8, NREGS=4. LDI R0=200, LDI R1=3, MUL. Required: {HI,LO}=signed(-56*3)=0xFF58, i.e. HI=0xFF, LO=0x58.
